spi_master_byte: RTL and testbench
==================================

# spi_master_byte

Byte-wide SPI master engine (mode 0, MSB first) that sits between the CPU core's memory/IO sequencer and the SPI pins on `uio`. The CPU issues one byte per `start`, and the block drives `spi_cs_n`, `spi_sck` and `spi_mosi` while shifting in `spi_miso`. It returns the received byte with a one-cycle `done` pulse. Chip select can be held across bytes so the CPU can issue multi-byte RAM commands such as opcode, address and data.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  request a byte transfer; sampled when `busy`=0
- `keep_cs`  in  1  sampled with `start`; 1 = leave CS asserted after this byte
- `cs_release`  in  1  while CS is held and idle, deassert CS
- `tx_data`  in  8  byte to send; sampled with `start`
- `rx_data`  out  8  last received byte; updated only on `done`
- `busy`  out  1  transfer or deselect tail in progress
- `done`  out  1  one-cycle pulse when the byte completes
- `spi_cs_n`  out  1  chip select, active low
- `spi_sck`  out  1  serial clock, idle low
- `spi_mosi`  out  1  serial data out
- `spi_miso`  in  1  serial data in

## Operation
- States:
  - `IDLE` (CS high).
  - `SHIFT` (byte in flight).
  - `HELD` (CS low, no transfer).
  - `TAIL` (CS high, deselect time).
- Reset values, applied immediately on `rst`:
  - `spi_cs_n`=1; `spi_sck`=0; `spi_mosi`=0.
  - `busy`=0; `done`=0; `rx_data`=0x00.
  - State `IDLE`; all counters 0.
- IDLE/HELD + `start` → SHIFT:
  - Latch `tx_data` and `keep_cs`.
  - `spi_cs_n`=0, `spi_sck`=0, `spi_mosi`=`tx_data[7]`.
- SHIFT, per bit (8 bits total):
  - Low phase: CLK_DIV cycles with SCK low.
  - High phase: CLK_DIV cycles with SCK high.
  - `spi_miso` is sampled into the rx shift register on the clk edge where SCK rises.
  - On each falling SCK edge, MOSI advances to the next bit.
  - After the 8th falling edge, MOSI holds its last value.
- End of byte:
  - `done`=1 for one cycle.
  - `rx_data` ← the shifted byte.
  - Next state is HELD if the latched `keep_cs`=1, otherwise TAIL.
- HELD:
  - `busy`=0, CS low, SCK low.
  - `start` → SHIFT with no extra lead time.
  - `cs_release` → TAIL.
  - If `start` and `cs_release` are both high, `start` wins and `cs_release` is ignored.
- TAIL: `spi_cs_n`=1 for CLK_DIV cycles with `busy`=1, then → IDLE.
- Ignored inputs:
  - `start` while `busy`=1.
  - `cs_release` in IDLE, SHIFT or TAIL.
- Width rules:
  - Bit counter: 3 bits; wraps after bit 0 is sent.
  - Phase counter: 8 bits; reloads at every SCK edge.

## Timing
- Let T0 be the edge that accepts `start`.
- After T0: `busy`=1, CS low, MOSI=bit 7.
- SCK rising edge k (k=1..8) occurs at T0+(2k−1)·CLK_DIV; MISO is sampled there.
- SCK falling edge k occurs at T0+2k·CLK_DIV.
- After T0+16·CLK_DIV: `done`=1 and `rx_data` is valid.
  - With `keep_cs`=1, `busy` also drops at this edge.
  - With `keep_cs`=0, CS rises at this edge and `busy` drops after T0+17·CLK_DIV.
- Earliest next `start`:
  - From HELD: the cycle `done` is high.
  - From TAIL: the cycle after `busy` falls.
- Reset mid-transfer: the byte is aborted, CS is deasserted asynchronously, and no `done` is issued.

## Structure
- Package `spi_pkg` holds:
  - The state enum (`IDLE`, `SHIFT`, `HELD`, `TAIL`).
  - The bit-count constant (8).
  - Mode constants (CPOL=0, CPHA=0).
- One sub-module, `spi_sck_gen`, covers:
  - The CLK_DIV phase counter and SCK toggle.
  - One-cycle `rise`/`fall` strobes.
  - An `en` input, held low to park SCK at 0 with the counter cleared.
- The top level `spi_master_byte` holds the FSM, shift registers and output registers.

## Test plan
- CLK_DIV=2, `tx_data`=0xA5, `keep_cs`=0, MISO looped to MOSI → `rx_data`=0xA5; `done` at T0+32; CS high from T0+32; `busy` low after T0+34.
- CLK_DIV=2, `tx_data`=0x3C, slave model returns 0xC3 → MOSI at the 8 rising edges reads 0,0,1,1,1,1,0,0; `rx_data`=0xC3.
- Chained bytes 0x03 (keep), 0x00 (keep), 0x00 (no keep), each `start` issued on the `done` cycle:
  - 24 SCK rising edges.
  - `spi_cs_n` low continuously, with one rising edge after the third byte.
  - Three `done` pulses.
- `start` pulsed while `busy` → ignored; exactly 8 SCK rising edges and one `done`.
- HELD + `cs_release` → CS high next cycle; `busy`=1 for CLK_DIV cycles, then IDLE.
- `rst` asserted after the 3rd rising SCK edge → immediately CS=1, SCK=0, `busy`=0, `rx_data`=0x00, no `done`; the next transfer of 0x5A completes normally.
- CLK_DIV=1 → SCK period of 2 clk; `done` at T0+16.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HELD  = 2'd2,
    TAIL  = 2'd3
  } spi_state_e;

  localparam int BITS_PER_BYTE = 8;

  // SPI mode 0: SCK idles low, data sampled on the leading (rising) edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: CLK_DIV clk cycles per half-period, with strobes that are
// high during the cycle whose closing clk edge toggles SCK.
import spi_pkg::*;

module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] phase_cnt;
  logic       edge_now;

  assign edge_now = en && (phase_cnt == LAST);
  assign rise     = edge_now && !sck;
  assign fall     = edge_now && sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
      sck       <= CPOL;
    end else if (!en) begin
      phase_cnt <= '0;
      sck       <= CPOL;
    end else if (phase_cnt == LAST) begin
      phase_cnt <= '0;
      sck       <= ~sck;
    end else begin
      phase_cnt <= phase_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_byte.sv
// Byte-wide SPI master (mode 0, MSB first) with optional CS hold across bytes.
// Handshake: start is accepted on any clk edge where busy is low; each accepted start yields exactly one done pulse.
import spi_pkg::*;

module spi_master_byte #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       keep_cs,
  input  logic       cs_release,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  spi_state_e state;
  logic       keep_q;
  logic [2:0] bit_cnt;
  logic [6:0] tx_sr;
  logic [7:0] rx_sr;
  logic [7:0] tail_cnt;
  logic       sck_en;
  logic       sck_rise;
  logic       sck_fall;
  logic       sample_stb;
  logic       shift_stb;

  assign sck_en = (state == SHIFT);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .sck  (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  assign sample_stb = (CPOL ^ CPHA) ? sck_fall : sck_rise;
  assign shift_stb  = (CPOL ^ CPHA) ? sck_rise : sck_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= 8'h00;
      keep_q   <= 1'b0;
      bit_cnt  <= 3'd0;
      tx_sr    <= 7'd0;
      rx_sr    <= 8'h00;
      tail_cnt <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, HELD: begin
          // start takes priority over cs_release when both arrive in HELD
          if (start) begin
            state    <= SHIFT;
            keep_q   <= keep_cs;
            tx_sr    <= tx_data[6:0];
            spi_mosi <= tx_data[7];
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= 3'(BITS_PER_BYTE - 1);
          end else if (state == HELD && cs_release) begin
            state    <= TAIL;
            spi_cs_n <= 1'b1;
            busy     <= 1'b1;
            tail_cnt <= 8'd0;
          end
        end
        SHIFT: begin
          if (sample_stb) begin
            rx_sr <= {rx_sr[6:0], spi_miso};
          end
          if (shift_stb) begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              done    <= 1'b1;
              rx_data <= rx_sr;
              if (keep_q) begin
                state <= HELD;
                busy  <= 1'b0;
              end else begin
                state    <= TAIL;
                spi_cs_n <= 1'b1;
                tail_cnt <= 8'd0;
              end
            end else begin
              spi_mosi <= tx_sr[6];
              tx_sr    <= {tx_sr[5:0], 1'b0};
            end
          end
        end
        TAIL: begin
          if (tail_cnt == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tail_cnt <= 8'd0;
          end else begin
            tail_cnt <= tail_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Self-checking bench for spi_master_byte: a timeline model derived from the
// byte-transfer rules, a SPI slave model, and a second instance at CLK_DIV=1.
module tb_spi_master_byte;

  localparam int D = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (CLK_DIV=2) ----------------
  logic       start, keep_cs, cs_release;
  logic [7:0] tx_data, rx_data;
  logic       busy, done, spi_cs_n, spi_sck, spi_mosi, spi_miso;

  spi_master_byte #(.CLK_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .keep_cs    (keep_cs),
    .cs_release (cs_release),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .busy       (busy),
    .done       (done),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  // ---------------- DUT (CLK_DIV=1), MISO looped to MOSI ----------------
  logic       s1_start;
  logic [7:0] s1_tx, s1_rx;
  logic       s1_busy, s1_done, s1_cs_n, s1_sck, s1_mosi;

  spi_master_byte #(.CLK_DIV(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (s1_start),
    .keep_cs    (1'b0),
    .cs_release (1'b0),
    .tx_data    (s1_tx),
    .rx_data    (s1_rx),
    .busy       (s1_busy),
    .done       (s1_done),
    .spi_cs_n   (s1_cs_n),
    .spi_sck    (s1_sck),
    .spi_mosi   (s1_mosi),
    .spi_miso   (s1_mosi)
  );

  // ---------------- pin monitor and slave model ----------------
  int         rises = 0, done_cnt = 0, cs_rises = 0, rise_base = 0;
  int         rise_cyc_q[$];
  logic       mosi_q[$];
  logic       sck_prev = 1'b0, cs_prev = 1'b1, loop_mode = 1'b0;
  logic [7:0] slave_byte = 8'h00;

  always @(negedge clk) begin
    int idx;
    if (spi_sck && !sck_prev) begin
      rises++;
      rise_cyc_q.push_back(cyc);
      mosi_q.push_back(spi_mosi);
    end
    if (done) done_cnt++;
    if (spi_cs_n && !cs_prev) cs_rises++;
    sck_prev = spi_sck;
    cs_prev  = spi_cs_n;
    // slave presents bit (7-idx) ahead of rising edge idx+1
    idx = rises - rise_base;
    if (loop_mode) spi_miso = spi_mosi;
    else if (idx >= 0 && idx < 8) spi_miso = slave_byte[7-idx];
    else spi_miso = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge. Returns on the done cycle when keep=1,
  // otherwise on the first cycle with busy low after the deselect tail.
  task automatic do_xfer(input logic [7:0] tx, input logic keep, input logic [7:0] sbyte,
                         input logic loop, input int poke_at, input logic rel);
    int         t0, base, budget;
    logic [7:0] exp_rx, mbits;
    exp_rx     = loop ? tx : sbyte;
    loop_mode  = loop;
    slave_byte = sbyte;
    rise_base  = rises;
    base       = rises;
    start      = 1'b1;
    tx_data    = tx;
    keep_cs    = keep;
    cs_release = rel;
    t0         = cyc + 1;
    @(negedge clk);
    start      = 1'b0;
    cs_release = 1'b0;
    tx_data    = 8'($urandom);
    keep_cs    = 1'($urandom);
    check("accept_busy", busy, 1);
    check("accept_cs_n", spi_cs_n, 0);
    check("accept_mosi", spi_mosi, tx[7]);
    check("accept_sck", spi_sck, 0);
    budget = 20 * D + 10;
    while (!done && budget > 0) begin
      if (poke_at > 0 && cyc == t0 + poke_at - 1) begin
        start      = 1'b1;
        cs_release = 1'b1;
        tx_data    = ~tx;
        keep_cs    = ~keep;
      end else begin
        start      = 1'b0;
        cs_release = 1'b0;
      end
      @(negedge clk);
      budget--;
    end
    start      = 1'b0;
    cs_release = 1'b0;
    check("done_seen", done, 1);
    check("done_cycle", cyc - t0, 16 * D);
    check("rx_data", rx_data, exp_rx);
    check("done_cs_n", spi_cs_n, !keep);
    check("done_busy", busy, !keep);
    check("rise_count", rises - base, 8);
    if (rises - base >= 8) begin
      for (int k = 1; k <= 8; k++) begin
        check("rise_cycle", rise_cyc_q[base+k-1] - t0, (2 * k - 1) * D);
        mbits[8-k] = mosi_q[base+k-1];
      end
      check("mosi_bits", mbits, tx);
    end
    if (!keep) begin
      for (int j = 1; j < D; j++) begin
        @(negedge clk);
        check("tail_busy", busy, 1);
        check("tail_cs_n", spi_cs_n, 1);
        check("done_pulse", done, 0);
      end
      @(negedge clk);
      check("tail_end_busy", busy, 0);
      check("tail_end_cs_n", spi_cs_n, 1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, c0, r0, base, n, t0;
    start = 1'b0; keep_cs = 1'b0; cs_release = 1'b0; tx_data = 8'h00;
    s1_start = 1'b0; s1_tx = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // loopback byte and a slave-returned byte
    do_xfer(8'hA5, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    do_xfer(8'h3C, 1'b0, 8'hC3, 1'b0, 0, 1'b0);

    // chained opcode/address/data with CS held
    d0 = done_cnt; c0 = cs_rises; r0 = rises;
    do_xfer(8'h03, 1'b1, 8'($urandom), 1'b0, 0, 1'b0);
    do_xfer(8'h00, 1'b1, 8'($urandom), 1'b0, 0, 1'b0);
    do_xfer(8'h00, 1'b0, 8'($urandom), 1'b0, 0, 1'b0);
    @(negedge clk);
    check("chain_rises", rises - r0, 24);
    check("chain_done", done_cnt - d0, 3);
    check("chain_cs_rises", cs_rises - c0, 1);

    // start and cs_release poked while busy
    d0 = done_cnt;
    do_xfer(8'($urandom), 1'b0, 8'($urandom), 1'b0, 5, 1'b0);
    @(negedge clk);
    check("ignored_start_done", done_cnt - d0, 1);

    // HELD, start+cs_release together, then release
    do_xfer(8'($urandom), 1'b1, 8'($urandom), 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("held_cs_n", spi_cs_n, 0);
    check("held_busy", busy, 0);
    check("held_sck", spi_sck, 0);
    do_xfer(8'($urandom), 1'b1, 8'($urandom), 1'b0, 0, 1'b1);
    repeat (2) @(negedge clk);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    check("release_cs_n", spi_cs_n, 1);
    check("release_busy", busy, 1);
    for (int j = 1; j < D; j++) begin
      @(negedge clk);
      check("release_tail_busy", busy, 1);
    end
    @(negedge clk);
    check("release_end_busy", busy, 0);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    check("idle_release_busy", busy, 0);
    check("idle_release_cs_n", spi_cs_n, 1);

    // random bytes, random CS hold, always ending deselected
    for (int i = 0; i < 6; i++) begin
      do_xfer(8'($urandom), (i == 5) ? 1'b0 : 1'($urandom_range(0, 1)),
              8'($urandom), 1'b0, 0, 1'b0);
    end

    // reset after the 3rd rising SCK edge
    d0 = done_cnt; base = rises; rise_base = rises; loop_mode = 1'b0;
    slave_byte = 8'($urandom);
    start = 1'b1; tx_data = 8'($urandom); keep_cs = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rises - base < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_rise3", (rises - base >= 3) ? 1 : 0, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sck", spi_sck, 0);
    check("abort_busy", busy, 0);
    check("abort_rx", rx_data, 8'h00);
    check("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    do_xfer(8'h5A, 1'b0, 8'h00, 1'b1, 0, 1'b0);

    // CLK_DIV=1 instance: SCK period of two clk cycles
    s1_tx = 8'($urandom);
    s1_start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    s1_start = 1'b0;
    check("div1_busy", s1_busy, 1);
    check("div1_cs_n", s1_cs_n, 0);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      check("div1_sck", s1_sck, j % 2);
      check("div1_done", s1_done, (j == 16) ? 1 : 0);
    end
    check("div1_done_cycle", cyc - t0, 16);
    check("div1_rx", s1_rx, s1_tx);
    @(negedge clk);
    check("div1_tail_end_busy", s1_busy, 0);
    check("div1_tail_cs_n", s1_cs_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
